gpio_in_cond: RTL and testbench



---
 rtl/gpio_in_cond.sv | 186 ++++++++++++++++++
 tb/tb_gpio_in_cond.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_cond.sv
// ---------------------------------------------------------------------------
// gpio_in_cond
//
// Input-conditioning stage placed directly in front of the GPIO register
// block. Raw pad levels pass through a 2-flop synchronizer and then a
// per-bit debounce filter. The filtered level is driven on gpio_in, which
// the register block reads back at address 0x08. Accepted transitions
// produce one-cycle rise/fall pulses. Enabled edges set a sticky
// interrupt status that is cleared by writing 1.
//
// Build option:
//   GPIO_DEBOUNCE_EN  defined   : per-bit counters; a new synchronized level
//                                 must persist DEB_CYCLES cycles to be accepted.
//                     undefined : no counters; gpio_in follows the synchronizer
//                                 one cycle later and DEB_CYCLES is ignored.
//
// Parameters:
//   WIDTH       number of GPIO bits
//   DEB_CYCLES  persistence requirement in synchronized cycles (1..255)
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset, clears all state
//   pad_in       raw pad levels, asynchronous to clk
//   irq_rise_en  per-bit enable: a rising edge sets irq_status
//   irq_fall_en  per-bit enable: a falling edge sets irq_status
//   irq_clr      per-bit write-1-to-clear strobe for irq_status
//   gpio_in      debounced, synchronized level
//   rise_pulse   one-cycle pulse when a gpio_in bit goes 0->1
//   fall_pulse   one-cycle pulse when a gpio_in bit goes 1->0
//   irq_status   sticky per-bit edge status
//   irq          OR-reduction of irq_status
// ---------------------------------------------------------------------------
module gpio_in_cond #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pad_in,
    input  logic [WIDTH-1:0] irq_rise_en,
    input  logic [WIDTH-1:0] irq_fall_en,
    input  logic [WIDTH-1:0] irq_clr,
    output logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic [WIDTH-1:0] irq_status,
    output logic             irq
);

    // Elaboration-time guard on the debounce length.
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range_check
        $error("gpio_in_cond: DEB_CYCLES must be in 1..255");
    end

    // -----------------------------------------------------------------------
    // 2-flop synchronizer: the only logic that samples pad_in.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= pad_in;
            s2_q <= s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Acceptance of a new level, per bit.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] accept;

`ifdef GPIO_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [WIDTH-1:0][CW-1:0] cnt_q;
    logic [WIDTH-1:0][CW-1:0] cnt_d;

    // The counter holds the number of consecutive mismatching cycles already
    // seen. The cycle that would take it to DEB_CYCLES is the accept cycle,
    // so the counter never reaches DEB_CYCLES itself. Any cycle in which the
    // synchronized level matches gpio_in (or an accept) restarts it from 0.
    always_comb begin
        cnt_d  = '0;
        accept = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Without the filter every synchronized difference is accepted at once.
    always_comb begin
        accept = s2_q ^ stable_q;
    end
`endif

    // Accepted bits flip; since accept implies s2 != stable this equals s2.
    always_comb begin
        stable_d = stable_q ^ accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_d;
        end
    end

    // -----------------------------------------------------------------------
    // Edge pulses, registered on the accept edge so that each pulse lines up
    // with the first cycle gpio_in shows the new level.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_q;
    logic [WIDTH-1:0] fall_d;

    always_comb begin
        rise_d = accept &  s2_q;
        fall_d = accept & ~s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sticky interrupt status. Set is evaluated from the pulses of the
    // current cycle and the enables of the current cycle only, and it is
    // OR-ed in after the clear so a simultaneous set wins.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] status_set;

    always_comb begin
        status_set = (rise_q & irq_rise_en) | (fall_q & irq_fall_en);
        status_d   = (status_q & ~irq_clr) | status_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign gpio_in    = stable_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign irq_status = status_q;
    assign irq        = |status_q;

endmodule

// File: tb/tb_gpio_in_cond.sv
// ---------------------------------------------------------------------------
// tb_gpio_in_cond
//
// Bench for gpio_in_cond. Edge numbering in the directed tasks: inputs are
// changed on a falling clock edge, and "edge k" is the k-th rising edge
// after that change (k starts at 1). A new pad level therefore shows on
// gpio_in after edge 2+D, where D is the effective debounce length
// (DEB_CYCLES with GPIO_DEBOUNCE_EN, otherwise 1).
//
// The reference model keeps a history of pad samples. A bit is accepted
// when the last D synchronized samples (pad taken two edges earlier) all
// differ from the current level.
// ---------------------------------------------------------------------------
module tb_gpio_in_cond;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEB   = 4;
`ifdef GPIO_DEBOUNCE_EN
    localparam int D = DEB;
`else
    localparam int D = 1;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] pad_in      = '0;
    logic [WIDTH-1:0] irq_rise_en = '0;
    logic [WIDTH-1:0] irq_fall_en = '0;
    logic [WIDTH-1:0] irq_clr     = '0;
    logic [WIDTH-1:0] gpio_in;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic [WIDTH-1:0] irq_status;
    logic             irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gpio_in_cond #(
        .WIDTH      (WIDTH),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pad_in      (pad_in),
        .irq_rise_en (irq_rise_en),
        .irq_fall_en (irq_fall_en),
        .irq_clr     (irq_clr),
        .gpio_in     (gpio_in),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .irq_status  (irq_status),
        .irq         (irq)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_lvl, m_rp, m_fp, m_st;

    function automatic logic [WIDTH-1:0] model_accept();
        logic [WIDTH-1:0] a;
        a = '1;
        // hist[$] is the pad sampled one edge ago; the filter sees the one
        // sampled two edges ago, and the D samples before it.
        for (int k = 0; k < D; k++) begin
            a = a & (hist[hist.size() - 2 - k] ^ m_lvl);
        end
        return a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back('0);
            m_lvl <= '0;
            m_rp  <= '0;
            m_fp  <= '0;
            m_st  <= '0;
        end else begin
            m_st  <= (m_st & ~irq_clr) | (m_rp & irq_rise_en) | (m_fp & irq_fall_en);
            m_rp  <= model_accept() & ~m_lvl;
            m_fp  <= model_accept() &  m_lvl;
            m_lvl <= m_lvl ^ model_accept();
            hist.push_back(pad_in);
            if (hist.size() > D + 4) void'(hist.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helper: reset with given pad level, release on falling edge.
    // ------------------------------------------------------------------
    task automatic do_reset(input logic [WIDTH-1:0] pad);
        @(negedge clk);
        rst_n       = 1'b0;
        pad_in      = pad;
        irq_rise_en = '0;
        irq_fall_en = '0;
        irq_clr     = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [WIDTH-1:0] exp_g, exp_r;
        @(negedge clk);
        rst_n       = 1'b0;
        pad_in      = '1;
        irq_rise_en = '1;
        irq_fall_en = '1;
        irq_clr     = '0;
        #1;
        total++;
        if ({gpio_in, rise_pulse, fall_pulse, irq_status, irq} !== '0) begin
            bad++;
            $display("FAIL reset_async got g=%h r=%h f=%h s=%h i=%b want all 0",
                     gpio_in, rise_pulse, fall_pulse, irq_status, irq);
        end
        repeat (3) @(negedge clk);
        total++;
        if ({gpio_in, rise_pulse, fall_pulse, irq_status, irq} !== '0) begin
            bad++;
            $display("FAIL reset_held got g=%h r=%h f=%h s=%h i=%b want all 0",
                     gpio_in, rise_pulse, fall_pulse, irq_status, irq);
        end
        irq_rise_en = '0;
        irq_fall_en = '0;
        rst_n = 1'b1;
        for (int k = 1; k <= D + 4; k++) begin
            @(negedge clk);
            exp_g = (k >= 2 + D) ? '1 : '0;
            exp_r = (k == 2 + D) ? '1 : '0;
            total++;
            if (gpio_in !== exp_g) begin
                bad++;
                $display("FAIL reset_release_gpio edge=%0d got %h want %h", k, gpio_in, exp_g);
            end
            total++;
            if (rise_pulse !== exp_r) begin
                bad++;
                $display("FAIL reset_release_rise edge=%0d got %h want %h", k, rise_pulse, exp_r);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clean_rise();
        do_reset('0);
        irq_rise_en[3] = 1'b1;
        pad_in[3]      = 1'b1;
        for (int k = 1; k <= D + 8; k++) begin
            @(negedge clk);
            total++;
            if ({gpio_in[3], rise_pulse[3], irq_status[3], irq}
                !== {1'(k >= 2 + D), 1'(k == 2 + D), 1'(k >= 3 + D), 1'(k >= 3 + D)}) begin
                bad++;
                $display("FAIL clean_rise edge=%0d got g=%b r=%b s=%b i=%b want g=%b r=%b s=%b i=%b",
                         k, gpio_in[3], rise_pulse[3], irq_status[3], irq,
                         k >= 2 + D, k == 2 + D, k >= 3 + D, k >= 3 + D);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Pad bit high for exactly L sampled cycles, no interrupts enabled.
    task automatic test_pulse(input int b, input int L);
        logic pass, eg, er, ef;
        do_reset('0);
        pass = (L >= D);
        pad_in[b] = 1'b1;
        for (int k = 1; k <= L + D + 6; k++) begin
            @(negedge clk);
            if (k == L) pad_in[b] = 1'b0;
            eg = pass && (k >= 2 + D) && (k <= L + 1 + D);
            er = pass && (k == 2 + D);
            ef = pass && (k == L + 2 + D);
            total++;
            if ({gpio_in[b], rise_pulse[b], fall_pulse[b], irq_status, irq}
                !== {eg, er, ef, {WIDTH{1'b0}}, 1'b0}) begin
                bad++;
                $display("FAIL pulse_b%0d_L%0d edge=%0d got g=%b r=%b f=%b s=%h want g=%b r=%b f=%b s=0",
                         b, L, k, gpio_in[b], rise_pulse[b], fall_pulse[b], irq_status, eg, er, ef);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_clear_collision();
        do_reset('0);
        irq_rise_en[3] = 1'b1;
        irq_fall_en[3] = 1'b1;
        pad_in[3]      = 1'b1;
        repeat (D + 4) @(negedge clk);
        // separate clear with no edge
        irq_clr[3] = 1'b1;
        @(negedge clk);
        irq_clr[3] = 1'b0;
        total++;
        if ({irq_status[3], irq} !== 2'b00) begin
            bad++;
            $display("FAIL clear_plain got s=%b i=%b want s=0 i=0", irq_status[3], irq);
        end
        // falling edge; clear strobe sampled on the same edge that sets
        pad_in[3] = 1'b0;
        for (int k = 1; k <= D + 2; k++) begin
            @(negedge clk);
            irq_clr[3] = (k == D + 2);
        end
        @(negedge clk);
        irq_clr[3] = 1'b0;
        total++;
        if ({irq_status[3], irq} !== 2'b11) begin
            bad++;
            $display("FAIL clear_vs_set got s=%b i=%b want s=1 i=1", irq_status[3], irq);
        end
        irq_clr[3] = 1'b1;
        @(negedge clk);
        irq_clr[3] = 1'b0;
        total++;
        if ({irq_status[3], irq} !== 2'b00) begin
            bad++;
            $display("FAIL clear_after got s=%b i=%b want s=0 i=0", irq_status[3], irq);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_disabled_edge();
        do_reset('0);
        pad_in[7] = 1'b1;
        repeat (D + 4) @(negedge clk);
        pad_in[7] = 1'b0;
        for (int k = 1; k <= D + 6; k++) begin
            @(negedge clk);
            total++;
            if ({fall_pulse[7], irq_status[7]} !== {1'(k == 2 + D), 1'b0}) begin
                bad++;
                $display("FAIL disabled_fall edge=%0d got f=%b s=%b want f=%b s=0",
                         k, fall_pulse[7], irq_status[7], k == 2 + D);
            end
        end
        irq_fall_en[7] = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({irq_status[7], irq} !== 2'b00) begin
            bad++;
            $display("FAIL disabled_late_enable got s=%b i=%b want 0 0", irq_status[7], irq);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_debounce();
        logic [WIDTH-1:0] exp_r;
        do_reset('0);
        pad_in = '1;
        repeat (D + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({gpio_in, rise_pulse, irq_status} !== '0) begin
            bad++;
            $display("FAIL mid_reset_async got g=%h r=%h s=%h want 0", gpio_in, rise_pulse, irq_status);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= D + 3; k++) begin
            @(negedge clk);
            exp_r = (k == 2 + D) ? '1 : '0;
            total++;
            if (rise_pulse !== exp_r) begin
                bad++;
                $display("FAIL mid_reset_requalify edge=%0d got %h want %h", k, rise_pulse, exp_r);
            end
        end
    endtask

    // ------------------------------------------------------------------
    // All bits toggle together, each level held exactly D cycles.
    task automatic test_back_to_back();
        do_reset('0);
        irq_rise_en = '1;
        irq_fall_en = 32'h0F0F_0F0F;
        for (int n = 0; n < 12 * D + 10; n++) begin
            if (n % D == 0 && n < 12 * D) pad_in = ~pad_in;
            @(negedge clk);
            total++;
            if ({gpio_in, rise_pulse, fall_pulse, irq_status, irq} !== {m_lvl, m_rp, m_fp, m_st, |m_st}) begin
                bad++;
                $display("FAIL b2b_model n=%0d got g=%h r=%h f=%h s=%h i=%b want g=%h r=%h f=%h s=%h i=%b",
                         n, gpio_in, rise_pulse, fall_pulse, irq_status, irq,
                         m_lvl, m_rp, m_fp, m_st, |m_st);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        do_reset($urandom);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            total++;
            if ({gpio_in, rise_pulse, fall_pulse, irq_status, irq} !== {m_lvl, m_rp, m_fp, m_st, |m_st}) begin
                bad++;
                $display("FAIL rand_model n=%0d got g=%h r=%h f=%h s=%h i=%b want g=%h r=%h f=%h s=%h i=%b",
                         n, gpio_in, rise_pulse, fall_pulse, irq_status, irq,
                         m_lvl, m_rp, m_fp, m_st, |m_st);
            end
            pad_in  = pad_in ^ ($urandom & $urandom & $urandom & $urandom);
            irq_clr = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 15) == 0) irq_rise_en = $urandom;
            if ($urandom_range(0, 15) == 0) irq_fall_en = $urandom;
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_pulse(5, 3);
        test_pulse(0, 2);
        test_pulse(9, D);
        test_clear_collision();
        test_disabled_edge();
        test_reset_mid_debounce();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
